// File: rtl/display_trace_buffer.sv
// rtl/display_trace_buffer.sv - trace FIFO replaying captured op-code/R16 pairs to the 7-segment display stage
// Optional feature macro: DISPLAY_TRACE_FREEZE_EN (adds the freeze input that pauses replay in SHOW).
module display_trace_buffer #(
   parameter int DEPTH       = 8,
   parameter int HOLD_CYCLES = 25_000_000
) (
   input  logic                     clock,
   input  logic                     reset_s2_n,
   input  logic                     capture,
   input  logic [7:0]               cpu_op_code,
   input  logic [7:0]               cpu_r16,
   input  logic                     clear,
`ifdef DISPLAY_TRACE_FREEZE_EN
   input  logic                     freeze,
`endif
   output logic                     enable,
   output logic [7:0]               op_code,
   output logic [7:0]               r16,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(HOLD_CYCLES);

   localparam logic [TW-1:0] TIMER_LAST = TW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_SHOW = 2'd2;

   logic [15:0]   mem [DEPTH];

   logic [1:0]    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          overflow_q, overflow_d;
   logic          enable_q, enable_d;
   logic [7:0]    op_q, op_d;
   logic [7:0]    r16_q, r16_d;

   logic          freeze_w;
   logic          pop;
   logic          push;
   logic          drop;
   logic [15:0]   head;

`ifdef DISPLAY_TRACE_FREEZE_EN
   assign freeze_w = freeze;
`else
   assign freeze_w = 1'b0;
`endif

   // FIFO handshake: a pop happens on the LOAD exit edge; a capture into a full
   // FIFO is still accepted when that same edge frees a slot. clear wins over both.
   always_comb begin
      pop  = (state_q == S_LOAD) && !clear;
      push = capture && !clear && (!full_q || pop);
      drop = capture && !clear && full_q && !pop;
      head = mem[rd_ptr_q];
   end

   // FIFO bookkeeping; flags are derived from the next count so they stay registered
   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (clear) begin
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d    = count_q + CW'(push) - CW'(pop);
         overflow_d = overflow_q | drop;
      end
      full_d  = (count_d == COUNT_FULL);
      empty_d = (count_d == '0);
   end

   // Replay sequencer: IDLE waits for data, LOAD pops one entry, SHOW holds it
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      enable_d = enable_q;
      op_d     = op_q;
      r16_d    = r16_q;
      if (clear) begin
         state_d  = S_IDLE;
         timer_d  = '0;
         enable_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               enable_d = 1'b0;
               if (!empty_q) state_d = S_LOAD;
            end
            S_LOAD: begin
               {op_d, r16_d} = head;
               enable_d      = 1'b1;
               timer_d       = '0;
               state_d       = S_SHOW;
            end
            S_SHOW: begin
               // Timer saturates at its last value so the final entry stays up
               if (!freeze_w) begin
                  if (timer_q != TIMER_LAST) begin
                     timer_d = timer_q + TW'(1);
                  end else if (!empty_q) begin
                     state_d = S_LOAD;
                  end
               end
            end
            default: begin
               state_d  = S_IDLE;
               timer_d  = '0;
               enable_d = 1'b0;
            end
         endcase
      end
   end

   // Entry storage; contents need no reset because the pointers define validity
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr_q] <= {cpu_op_code, cpu_r16};
   end

   // State and FIFO registers with asynchronous active-low reset
   always_ff @(posedge clock or negedge reset_s2_n) begin
      if (!reset_s2_n) begin
         state_q    <= S_IDLE;
         timer_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
         enable_q   <= 1'b0;
         op_q       <= 8'h00;
         r16_q      <= 8'h00;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         overflow_q <= overflow_d;
         enable_q   <= enable_d;
         op_q       <= op_d;
         r16_q      <= r16_d;
      end
   end

   assign enable   = enable_q;
   assign op_code  = op_q;
   assign r16      = r16_q;
   assign count    = count_q;
   assign full     = full_q;
   assign empty    = empty_q;
   assign overflow = overflow_q;

endmodule
